// File: rtl/sdram_bus_scheduler.sv
// Purpose: sequences the shared SDRAM pin bus: power-up wait, init, then one engine at a time (refresh first, read/write round-robin).
// Latency: enb/start assert one cycle after IDLE samples a request; every grant is followed by at least one all-low IDLE cycle.
// Backpressure: a request is held by its requester until fin; an open grant is never preempted and is closed by a watchdog.
module sdram_bus_scheduler #(
    parameter int INIT_WAIT      = 10000,
    parameter int REFRESH_PERIOD = 390,
    parameter int TIMEOUT        = 64,
    parameter int PEND_MAX       = 7
) (
    input  logic       iclk,
    input  logic       ctr_reset,
    output logic       init_enb,
    output logic       init_start,
    input  logic       init_fin,
    output logic       ref_enb,
    output logic       ref_start,
    input  logic       ref_fin,
    input  logic       rd_req,
    output logic       rd_enb,
    output logic       rd_start,
    input  logic       rd_fin,
    input  logic       wr_req,
    output logic       wr_enb,
    output logic       wr_start,
    input  logic       wr_fin,
    output logic       ready,
    output logic [2:0] ref_pending,
    output logic       ref_overflow,
    output logic       timeout_err
);

    localparam int DW = (INIT_WAIT > 1) ? $clog2(INIT_WAIT) : 1;
    localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int RW = (REFRESH_PERIOD > 1) ? $clog2(REFRESH_PERIOD) : 1;

    typedef enum logic [2:0] {
        S_PWRUP,
        S_INIT,
        S_IDLE,
        S_REF,
        S_RD,
        S_WR
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [DW-1:0]  dly_cnt;
    logic [WW-1:0]  wd_cnt;
    logic [RW-1:0]  ref_tmr;
    logic           last_rd;     // 1: read was served last, so write wins the next tie
    logic           wd_expire;
    logic           to_hit;      // watchdog fired this cycle
    logic           init_retry;  // init timed out, re-enter INIT
    logic           ref_done;
    logic           rd_done;
    logic           wr_done;
    logic           ref_wrap;
    logic           grant_entry;

    assign wd_expire   = (wd_cnt == WW'(TIMEOUT - 1));
    assign ref_wrap    = ready && (ref_tmr == RW'(REFRESH_PERIOD - 1));
    assign grant_entry = (state_nxt != state) || init_retry;

    // State register.
    always_ff @(posedge iclk or posedge ctr_reset) begin
        if (ctr_reset) begin
            state <= S_PWRUP;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode plus the completion/timeout events it implies.
    always_comb begin
        state_nxt  = state;
        to_hit     = 1'b0;
        init_retry = 1'b0;
        ref_done   = 1'b0;
        rd_done    = 1'b0;
        wr_done    = 1'b0;
        case (state)
            S_PWRUP: begin
                if (dly_cnt == DW'(INIT_WAIT - 1)) begin
                    state_nxt = S_INIT;
                end
            end
            S_INIT: begin
                if (init_fin) begin
                    state_nxt = S_IDLE;
                end else if (wd_expire) begin
                    to_hit     = 1'b1;
                    init_retry = 1'b1;
                end
            end
            S_IDLE: begin
                if (ref_pending != 3'd0) begin
                    state_nxt = S_REF;
                end else if (rd_req && wr_req) begin
                    state_nxt = last_rd ? S_WR : S_RD;
                end else if (rd_req) begin
                    state_nxt = S_RD;
                end else if (wr_req) begin
                    state_nxt = S_WR;
                end
            end
            S_REF: begin
                if (ref_fin) begin
                    state_nxt = S_IDLE;
                    ref_done  = 1'b1;
                end else if (wd_expire) begin
                    state_nxt = S_IDLE;
                    ref_done  = 1'b1;
                    to_hit    = 1'b1;
                end
            end
            S_RD: begin
                if (rd_fin) begin
                    state_nxt = S_IDLE;
                    rd_done   = 1'b1;
                end else if (wd_expire) begin
                    state_nxt = S_IDLE;
                    rd_done   = 1'b1;
                    to_hit    = 1'b1;
                end
            end
            S_WR: begin
                if (wr_fin) begin
                    state_nxt = S_IDLE;
                    wr_done   = 1'b1;
                end else if (wd_expire) begin
                    state_nxt = S_IDLE;
                    wr_done   = 1'b1;
                    to_hit    = 1'b1;
                end
            end
            default: state_nxt = S_PWRUP;
        endcase
    end

    // Power-up delay counter, only live in PWRUP.
    always_ff @(posedge iclk or posedge ctr_reset) begin
        if (ctr_reset) begin
            dly_cnt <= '0;
        end else if (state == S_PWRUP) begin
            dly_cnt <= dly_cnt + 1'b1;
        end else begin
            dly_cnt <= '0;
        end
    end

    // Grant watchdog: cleared on every grant entry, counts while a grant is open.
    always_ff @(posedge iclk or posedge ctr_reset) begin
        if (ctr_reset) begin
            wd_cnt <= '0;
        end else if (grant_entry) begin
            wd_cnt <= '0;
        end else if (state != S_PWRUP && state != S_IDLE) begin
            wd_cnt <= wd_cnt + 1'b1;
        end
    end

    // Registered enables and start pulses, decoded from the next state.
    always_ff @(posedge iclk or posedge ctr_reset) begin
        if (ctr_reset) begin
            init_enb   <= 1'b0;
            init_start <= 1'b0;
            ref_enb    <= 1'b0;
            ref_start  <= 1'b0;
            rd_enb     <= 1'b0;
            rd_start   <= 1'b0;
            wr_enb     <= 1'b0;
            wr_start   <= 1'b0;
        end else begin
            init_enb   <= (state_nxt == S_INIT);
            init_start <= (state_nxt == S_INIT) && grant_entry;
            ref_enb    <= (state_nxt == S_REF);
            ref_start  <= (state_nxt == S_REF) && grant_entry;
            rd_enb     <= (state_nxt == S_RD);
            rd_start   <= (state_nxt == S_RD) && grant_entry;
            wr_enb     <= (state_nxt == S_WR);
            wr_start   <= (state_nxt == S_WR) && grant_entry;
        end
    end

    // Ready flag, sticky timeout flag and round-robin pointer.
    always_ff @(posedge iclk or posedge ctr_reset) begin
        if (ctr_reset) begin
            ready       <= 1'b0;
            timeout_err <= 1'b0;
            last_rd     <= 1'b1;
        end else begin
            if (state == S_INIT && init_fin) begin
                ready <= 1'b1;
            end
            if (to_hit) begin
                timeout_err <= 1'b1;
            end
            if (rd_done) begin
                last_rd <= 1'b1;
            end else if (wr_done) begin
                last_rd <= 1'b0;
            end
        end
    end

    // Refresh timer and owed-refresh counter; a demand at saturation is recorded as overflow.
    always_ff @(posedge iclk or posedge ctr_reset) begin
        if (ctr_reset) begin
            ref_tmr      <= '0;
            ref_pending  <= 3'd0;
            ref_overflow <= 1'b0;
        end else begin
            if (ready) begin
                ref_tmr <= ref_wrap ? '0 : ref_tmr + 1'b1;
            end
            if (ref_wrap && ref_pending == 3'(PEND_MAX)) begin
                ref_overflow <= 1'b1;
            end
            if (ref_wrap && !ref_done) begin
                if (ref_pending != 3'(PEND_MAX)) begin
                    ref_pending <= ref_pending + 3'd1;
                end
            end else if (ref_done && !ref_wrap) begin
                if (ref_pending != 3'd0) begin
                    ref_pending <= ref_pending - 3'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_sdram_bus_scheduler.sv
// Purpose: directed bench for sdram_bus_scheduler: power-up, contention, refresh priority, timeout, overflow, async reset.
// Latency: checks sample 1 time unit after the rising edge; inputs change at the same point and are seen on the next edge.
// Backpressure: two instances share clock/reset; unit a uses TIMEOUT=16, unit b a long TIMEOUT to hold the bus for overflow.
module tb_sdram_bus_scheduler;

    logic iclk;
    logic ctr_reset;

    logic a_init_enb, a_init_start, a_init_fin;
    logic a_ref_enb, a_ref_start, a_ref_fin;
    logic a_rd_req, a_rd_enb, a_rd_start, a_rd_fin;
    logic a_wr_req, a_wr_enb, a_wr_start, a_wr_fin;
    logic a_ready, a_ref_overflow, a_timeout_err;
    logic [2:0] a_ref_pending;

    logic b_init_enb, b_init_start, b_init_fin;
    logic b_ref_enb, b_ref_start, b_ref_fin;
    logic b_rd_req, b_rd_enb, b_rd_start, b_rd_fin;
    logic b_wr_req, b_wr_enb, b_wr_start, b_wr_fin;
    logic b_ready, b_ref_overflow, b_timeout_err;
    logic [2:0] b_ref_pending;

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;
    int viol  = 0;

    sdram_bus_scheduler #(
        .INIT_WAIT(8), .REFRESH_PERIOD(20), .TIMEOUT(16), .PEND_MAX(7)
    ) u_a (
        .iclk(iclk), .ctr_reset(ctr_reset),
        .init_enb(a_init_enb), .init_start(a_init_start), .init_fin(a_init_fin),
        .ref_enb(a_ref_enb), .ref_start(a_ref_start), .ref_fin(a_ref_fin),
        .rd_req(a_rd_req), .rd_enb(a_rd_enb), .rd_start(a_rd_start), .rd_fin(a_rd_fin),
        .wr_req(a_wr_req), .wr_enb(a_wr_enb), .wr_start(a_wr_start), .wr_fin(a_wr_fin),
        .ready(a_ready), .ref_pending(a_ref_pending),
        .ref_overflow(a_ref_overflow), .timeout_err(a_timeout_err)
    );

    sdram_bus_scheduler #(
        .INIT_WAIT(8), .REFRESH_PERIOD(20), .TIMEOUT(250), .PEND_MAX(7)
    ) u_b (
        .iclk(iclk), .ctr_reset(ctr_reset),
        .init_enb(b_init_enb), .init_start(b_init_start), .init_fin(b_init_fin),
        .ref_enb(b_ref_enb), .ref_start(b_ref_start), .ref_fin(b_ref_fin),
        .rd_req(b_rd_req), .rd_enb(b_rd_enb), .rd_start(b_rd_start), .rd_fin(b_rd_fin),
        .wr_req(b_wr_req), .wr_enb(b_wr_enb), .wr_start(b_wr_start), .wr_fin(b_wr_fin),
        .ready(b_ready), .ref_pending(b_ref_pending),
        .ref_overflow(b_ref_overflow), .timeout_err(b_timeout_err)
    );

    initial iclk = 1'b0;
    always #5 iclk = ~iclk;

    // Bus-exclusivity monitor on the falling edge.
    always @(negedge iclk) begin
        if (int'(a_init_enb) + int'(a_ref_enb) + int'(a_rd_enb) + int'(a_wr_enb) > 1) viol++;
        if (int'(b_init_enb) + int'(b_ref_enb) + int'(b_rd_enb) + int'(b_wr_enb) > 1) viol++;
    end

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", tag, cyc, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge iclk);
        #1;
        cyc++;
    endtask

    task automatic tick_to(input int n);
        while (cyc < n) tick();
    endtask

    function automatic int a_outs();
        return int'({a_init_enb, a_init_start, a_ref_enb, a_ref_start, a_rd_enb, a_rd_start,
                     a_wr_enb, a_wr_start, a_ready, a_ref_pending, a_ref_overflow, a_timeout_err});
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        ctr_reset  = 1'b1;
        a_init_fin = 0; a_ref_fin = 0; a_rd_req = 0; a_rd_fin = 0; a_wr_req = 0; a_wr_fin = 0;
        b_init_fin = 0; b_ref_fin = 0; b_rd_req = 0; b_rd_fin = 0; b_wr_req = 0; b_wr_fin = 0;
        repeat (2) @(posedge iclk);
        #1;
        check("reset_outs", a_outs(), 0);
        ctr_reset = 1'b0;
        cyc = 0;

        // Power-up and init handshake.
        tick_to(7);
        check("pwrup_init_enb7", int'(a_init_enb), 0);
        tick();
        check("init_enb8", int'(a_init_enb), 1);
        check("init_start8", int'(a_init_start), 1);
        tick();
        check("init_start9", int'(a_init_start), 0);
        check("init_enb9", int'(a_init_enb), 1);
        tick_to(15);
        check("ready15", int'(a_ready), 0);
        a_init_fin = 1;
        tick();
        check("ready16", int'(a_ready), 1);
        check("init_enb16", int'(a_init_enb), 0);

        // Contention: WR first (pointer favours write), then alternate.
        a_rd_req = 1; a_wr_req = 1;
        for (int g = 0; g < 4; g++) begin
            tick();
            check("cont_wr_start", int'(a_wr_start), (g % 2 == 0) ? 1 : 0);
            check("cont_rd_start", int'(a_rd_start), (g % 2 == 0) ? 0 : 1);
            check("cont_wr_enb", int'(a_wr_enb), (g % 2 == 0) ? 1 : 0);
            check("cont_rd_enb", int'(a_rd_enb), (g % 2 == 0) ? 0 : 1);
            tick();
            check("cont_start_pulse", int'(a_wr_start | a_rd_start), 0);
            tick();
            if (g % 2 == 0) a_wr_fin = 1; else a_rd_fin = 1;
            tick();
            a_wr_fin = 0; a_rd_fin = 0;
            check("cont_gap", int'(a_rd_enb | a_wr_enb | a_ref_enb), 0);
            if (g == 3) begin
                a_rd_req = 0; a_wr_req = 0;
            end
        end

        // Refresh priority with a stray wr_fin while not granted.
        tick();                                   // 33
        a_rd_req = 1; a_wr_fin = 1;
        tick();                                   // 34
        a_wr_fin = 0;
        check("rd_grant34", int'(a_rd_enb), 1);
        check("rd_start34", int'(a_rd_start), 1);
        tick();                                   // 35
        check("pending35", int'(a_ref_pending), 0);
        a_wr_fin = 1;
        tick();                                   // 36
        a_wr_fin = 0;
        check("pending36", int'(a_ref_pending), 1);
        check("stray_fin_ignored", int'(a_rd_enb), 1);
        tick();                                   // 37
        a_rd_fin = 1;
        tick();                                   // 38
        a_rd_fin = 0;
        check("rd_done38", int'(a_rd_enb), 0);
        tick();                                   // 39
        check("ref_enb39", int'(a_ref_enb), 1);
        check("ref_start39", int'(a_ref_start), 1);
        check("rd_held_off39", int'(a_rd_enb), 0);
        tick_to(41);
        a_ref_fin = 1;
        tick();                                   // 42
        a_ref_fin = 0;
        check("pending42", int'(a_ref_pending), 0);
        check("ref_enb42", int'(a_ref_enb), 0);
        tick();                                   // 43
        check("rd_after_ref", int'(a_rd_start), 1);
        tick_to(45);
        a_rd_fin = 1; a_rd_req = 0;
        tick();                                   // 46
        a_rd_fin = 0; a_wr_req = 1;

        // Watchdog on an unanswered WR grant.
        tick();                                   // 47
        check("wr_start47", int'(a_wr_start), 1);
        tick_to(62);
        check("wr_enb62", int'(a_wr_enb), 1);
        check("to_err62", int'(a_timeout_err), 0);
        tick();                                   // 63
        check("wr_enb63", int'(a_wr_enb), 0);
        check("to_err63", int'(a_timeout_err), 1);
        a_wr_req = 0;
        tick();                                   // 64
        check("ref_after_to", int'(a_ref_enb), 1);
        tick_to(66);
        a_ref_fin = 1;
        tick();                                   // 67
        a_ref_fin = 0;
        check("pending67", int'(a_ref_pending), 0);
        check("to_err_sticky", int'(a_timeout_err), 1);
        a_wr_req = 1;
        tick();                                   // 68
        check("wr_normal68", int'(a_wr_start), 1);
        tick_to(70);
        a_wr_fin = 1; a_wr_req = 0;
        tick();                                   // 71
        a_wr_fin = 0;
        check("wr_enb71", int'(a_wr_enb), 0);
        a_rd_req = 1;
        tick();                                   // 72
        check("rd_enb72", int'(a_rd_enb), 1);
        tick();                                   // 73

        // Asynchronous reset in the middle of an RD grant.
        #2;
        ctr_reset = 1'b1;
        a_init_fin = 0; a_rd_req = 0;
        #1;
        check("async_reset_outs", a_outs(), 0);
        @(posedge iclk);
        #1;
        ctr_reset = 1'b0;
        cyc = 0;
        tick_to(7);
        check("rerun_start7", int'(a_init_start), 0);
        tick();
        check("rerun_start8", int'(a_init_start), 1);

        // Unit b: hold the bus with an unfinished RD while refreshes pile up.
        tick_to(15);
        b_init_fin = 1;
        tick();                                   // 16
        check("b_ready16", int'(b_ready), 1);
        b_rd_req = 1;
        tick();                                   // 17
        check("b_rd_enb17", int'(b_rd_enb), 1);
        tick_to(23);
        check("a_init_to23", int'(a_timeout_err), 0);
        tick();                                   // 24
        check("a_init_to24", int'(a_timeout_err), 1);
        check("a_ready_retry", int'(a_ready), 0);
        tick_to(155);
        check("b_pending155", int'(b_ref_pending), 6);
        tick_to(175);
        check("b_pending175", int'(b_ref_pending), 7);
        check("b_ovf175", int'(b_ref_overflow), 0);
        tick();                                   // 176
        check("b_pending176", int'(b_ref_pending), 7);
        check("b_ovf176", int'(b_ref_overflow), 1);
        check("b_rd_held", int'(b_rd_enb), 1);

        check("onehot_enb", viol, 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
